mips150_io_ctrl: RTL and testbench
==================================

# mips150_io_ctrl

Memory-mapped I/O controller for the MIPS150 core, sitting beside DMEM in the M stage. It takes the X-stage IO store mask, address and store data from the memory map, and returns a registered 32-bit IO read word in the M stage, which feeds the DMEM/IO load mux. It contains a full-duplex 8N1 UART and a free-running 32-bit cycle counter.

## Interface
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115_200, UART bit rate; CYCLES_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division, 434 at defaults)
- clk  input  1  system clock; all state on posedge
- rst  input  1  reset, asynchronous, active-high
- StoreMask  input  4  IO byte write enables from the memory map; any nonzero value is a write
- Addr  input  8  byte address within the IO page (ALU result [7:0]), X stage
- WriteData  input  32  store data (register rt), X stage; only [7:0] used
- LoadIO  input  1  X-stage instruction is a load targeting IO
- ReadData  output  32  registered IO read word, valid in the M stage
- serial_in  input  1  UART receive line, asynchronous, idle high
- serial_out  output  1  UART transmit line, idle high

## Operation
- Register map (Addr[7:2], Addr[1:0] ignored):
  - 0x00 TX status, read: bit0 = tx_ready (transmitter idle); other bits 0
  - 0x04 RX status, read: bit0 = rx_valid, bit1 = rx_overrun (sticky); other bits 0
  - 0x08 TX data, write: WriteData[7:0] starts a frame if tx_ready=1; ignored when busy
  - 0x0C RX data, read: {24'b0, rx_byte}; a read clears rx_valid and rx_overrun
  - 0x10 cycle count, read: current counter; any write clears it
  - unmapped offsets read 32'h0; writes to them and to read-only offsets have no effect
- Reads are performed when LoadIO=1; ReadData is registered at that edge and holds until the next IO read. Side effects of a read (RX pop) occur at that same edge.
- TX FSM: IDLE -> START (serial_out=0) -> DATA (8 bits, LSB first) -> STOP (serial_out=1) -> IDLE. Each bit lasts CYCLES_PER_BIT cycles; tx_ready=1 only in IDLE.
- RX: serial_in passes through a 2-flop synchronizer. RX FSM: IDLE -> START on synchronized falling edge; START samples at CYCLES_PER_BIT/2 and returns to IDLE if the line is high (glitch). DATA samples 8 bits at bit centres, LSB first. STOP samples one bit: if 1, the byte is delivered; if 0 (framing error), it is discarded with no flag. In both cases the FSM returns to IDLE.
- Delivery: if rx_valid=0, rx_byte is loaded and rx_valid set. If rx_valid=1 and no pop occurs in the same cycle, the new byte is dropped and rx_overrun is set.
- Cycle counter: 32-bit, increments every cycle and wraps 0xFFFF_FFFF -> 0. A write to 0x10 loads 0, taking precedence over the increment.

## Timing
- Reset (async) values: ReadData=0, serial_out=1, tx_ready=1, rx_valid=0, rx_overrun=0, rx_byte=0, counter=0. Both FSMs are in IDLE.
- Reset mid-frame aborts the frame immediately. serial_out returns high without waiting for a clock edge.
- Read latency is 1 cycle: address is presented in X, ReadData is valid after the next posedge (M stage), matching the synchronous DMEM read.
- A cycle-count read returns the counter value from before the edge on which it is captured.
- A TX write at edge N sets tx_ready=0 after edge N; the start bit appears on serial_out after edge N.
- A frame occupies 10*CYCLES_PER_BIT cycles. tx_ready returns to 1 exactly at the end of the stop bit, and a write in that cycle is accepted.
- Pop and delivery in the same cycle: ReadData gets the old byte, rx_byte gets the new byte, rx_valid stays 1, and no overrun is flagged.
- rx_valid rises 1 cycle after the stop-bit sample.
- StoreMask and LoadIO both active in one cycle: the write and read are both performed. A status read reflects state before the write.

## Test plan
- Reset: assert rst asynchronously mid-TX-frame -> serial_out=1 immediately; a read of 0x00 returns 1 and a read of 0x04 returns 0.
- TX: write 0x5A to 0x08 -> serial_out shows 0, then bits 0,1,0,1,1,0,1,0, then 1, each 434 cycles; 0x00 reads 0 during the frame and 1 after 4340 cycles. A second write while busy is ignored.
- RX: drive frame 0xA5 on serial_in -> 0x04 reads 1; 0x0C returns 0x0000_00A5; 0x04 then reads 0.
- Overrun and framing: send 0x11 then 0x22 without popping -> 0x0C returns 0x11 and 0x04 showed 3 before the pop. A frame with stop bit 0 leaves rx_valid at 0.
- Counter: read 0x10 twice 10 cycles apart -> difference 10. Write 0x10 -> the next read is small (1 when read the cycle immediately after). Preload near 0xFFFF_FFFF via force -> wraps to 0.
- Read latency/unmapped: LoadIO with Addr=0x20 -> ReadData=0 one cycle later. Pop coinciding with the stop-bit sample -> old byte returned, new byte retained, rx_overrun=0.

Source files
------------

// File: rtl/mips150_io_ctrl_if.sv
// IO-page bus between the MIPS150 memory map and the IO controller.
// The master drives X-stage store/load controls; the slave returns the registered M-stage read word.
interface mips150_io_ctrl_if;
  logic [3:0]  StoreMask;
  logic [7:0]  Addr;
  logic [31:0] WriteData;
  logic        LoadIO;
  logic [31:0] ReadData;

  modport master (
    output StoreMask,
    output Addr,
    output WriteData,
    output LoadIO,
    input  ReadData
  );

  modport slave (
    input  StoreMask,
    input  Addr,
    input  WriteData,
    input  LoadIO,
    output ReadData
  );
endinterface

// File: rtl/mips150_io_ctrl.sv
// MIPS150 memory-mapped IO controller: 8N1 UART (TX and RX) plus a free-running cycle counter.
// Reads are captured into ReadData at the edge where LoadIO is high, giving one cycle of latency like DMEM.
module mips150_io_ctrl #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic              clk,
  input  logic              rst,
  mips150_io_ctrl_if.slave  bus,
  input  logic              serial_in,
  output logic              serial_out
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [5:0] REG_TX_STATUS = 6'h00;
  localparam logic [5:0] REG_RX_STATUS = 6'h01;
  localparam logic [5:0] REG_TX_DATA   = 6'h02;
  localparam logic [5:0] REG_RX_DATA   = 6'h03;
  localparam logic [5:0] REG_CYCLES    = 6'h04;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_sync1_q, rx_sync1_d;
  logic             rx_sync2_q, rx_sync2_d;
  logic             rx_last_q, rx_last_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_overrun_q, rx_overrun_d;

  logic [31:0]      cycle_cnt_q, cycle_cnt_d;
  logic [31:0]      read_data_q, read_data_d;

  logic [5:0]       reg_sel;
  logic             wr_en;
  logic             rd_en;
  logic             wr_tx;
  logic             wr_cycles;
  logic             rx_pop;
  logic             rx_deliver;
  logic             tx_ready;
  logic             unused_bus_bits;

  assign reg_sel         = bus.Addr[7:2];
  assign wr_en           = |bus.StoreMask;
  assign rd_en           = bus.LoadIO;
  assign wr_tx           = wr_en && (reg_sel == REG_TX_DATA);
  assign wr_cycles       = wr_en && (reg_sel == REG_CYCLES);
  assign rx_pop          = rd_en && (reg_sel == REG_RX_DATA);
  assign tx_ready        = (tx_state_q == TX_IDLE);
  assign unused_bus_bits = ^{bus.WriteData[31:8], bus.Addr[1:0]};
  assign bus.ReadData    = read_data_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (wr_tx) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = bus.WriteData[7:0];
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Line level follows the state directly, so an async reset forces it idle-high at once.
  always_comb begin
    serial_out = 1'b1;
    case (tx_state_q)
      TX_START: serial_out = 1'b0;
      TX_DATA:  serial_out = tx_shift_q[0];
      default:  serial_out = 1'b1;
    endcase
  end

  always_comb begin
    rx_sync1_d = serial_in;
    rx_sync2_d = rx_sync1_q;
    rx_last_d  = rx_sync2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_deliver = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_last_q && !rx_sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
          rx_deliver = rx_sync2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A pop in the same cycle as a delivery frees the slot, so the new byte is kept without overrun.
  always_comb begin
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    if (rx_pop) begin
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
    end
    if (rx_deliver) begin
      if (!rx_valid_q || rx_pop) begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    cycle_cnt_d = wr_cycles ? 32'd0 : cycle_cnt_q + 32'd1;
    read_data_d = read_data_q;
    if (rd_en) begin
      case (reg_sel)
        REG_TX_STATUS: read_data_d = {31'd0, tx_ready};
        REG_RX_STATUS: read_data_d = {30'd0, rx_overrun_q, rx_valid_q};
        REG_RX_DATA:   read_data_d = {24'd0, rx_byte_q};
        REG_CYCLES:    read_data_d = cycle_cnt_q;
        default:       read_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'd0;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_last_q    <= 1'b1;
      rx_byte_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      cycle_cnt_q  <= 32'd0;
      read_data_q  <= 32'd0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_sync1_q   <= rx_sync1_d;
      rx_sync2_q   <= rx_sync2_d;
      rx_last_q    <= rx_last_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      cycle_cnt_q  <= cycle_cnt_d;
      read_data_q  <= read_data_d;
    end
  end

endmodule

// File: tb/tb_mips150_io_ctrl.sv
// Directed bench for mips150_io_ctrl at default baud settings (434 cycles per bit).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_mips150_io_ctrl;

  localparam int CPB = 434;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic serial_out;
  int   total = 0;
  int   bad   = 0;

  mips150_io_ctrl_if bus_if ();

  mips150_io_ctrl #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (115_200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .serial_in (serial_in),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [31:0] d);
    bus_if.Addr   = a;
    bus_if.LoadIO = 1'b1;
    @(posedge clk);
    #1;
    bus_if.LoadIO = 1'b0;
    d = bus_if.ReadData;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [31:0] wd);
    bus_if.Addr      = a;
    bus_if.WriteData = wd;
    bus_if.StoreMask = 4'h1;
    @(posedge clk);
    #1;
    bus_if.StoreMask = 4'h0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      serial_in = 1'b0;
      else if (i == 9) serial_in = stop_bit;
      else             serial_in = b[i-1];
      wait_cycles(CPB);
    end
    serial_in = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    serial_in = 1'b1;
    bus_if.StoreMask = 4'h0;
    bus_if.Addr = 8'h00;
    bus_if.WriteData = 32'h0;
    bus_if.LoadIO = 1'b0;
    #12;
    total++;
    if (bus_if.ReadData !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_readdata: got %h expected %h", bus_if.ReadData, 32'h0);
    end
    total++;
    if (serial_out !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_serial_out: got %b expected 1", serial_out);
    end
    #10 rst = 1'b0;
    wait_cycles(2);
    io_read(8'h00, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("[TB] FAIL reset_tx_status: got %h expected %h", d, 32'h1);
    end
    io_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_rx_status: got %h expected %h", d, 32'h0);
    end
    io_read(8'h0C, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_rx_byte: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_tx;
    logic [31:0] d;
    logic [9:0]  exp_bits;
    exp_bits = 10'b1_0101_1010_0;
    io_write(8'h08, 32'h0000_005A);
    total++;
    if (serial_out !== 1'b0) begin
      bad++; $display("[TB] FAIL tx_start_edge: got %b expected 0", serial_out);
    end
    io_read(8'h00, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL tx_busy_status: got %h expected %h", d, 32'h0);
    end
    io_write(8'h08, 32'h0000_00FF);
    wait_cycles(CPB/2 - 2);
    for (int j = 0; j < 10; j++) begin
      total++;
      if (serial_out !== exp_bits[j]) begin
        bad++; $display("[TB] FAIL tx_bit%0d: got %b expected %b", j, serial_out, exp_bits[j]);
      end
      if (j < 9) wait_cycles(CPB);
    end
    wait_cycles(CPB/2 - 1);
    io_read(8'h00, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL tx_last_stop_cycle: got %h expected %h", d, 32'h0);
    end
    io_read(8'h00, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("[TB] FAIL tx_ready_after_frame: got %h expected %h", d, 32'h1);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    io_write(8'h08, 32'h0000_00C3);
    wait_cycles(1000);
    #2 rst = 1'b1;
    #1;
    total++;
    if (serial_out !== 1'b1) begin
      bad++; $display("[TB] FAIL midframe_reset_line: got %b expected 1", serial_out);
    end
    total++;
    if (bus_if.ReadData !== 32'h0) begin
      bad++; $display("[TB] FAIL midframe_reset_readdata: got %h expected %h", bus_if.ReadData, 32'h0);
    end
    #3 rst = 1'b0;
    wait_cycles(1);
    io_read(8'h00, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("[TB] FAIL midframe_tx_status: got %h expected %h", d, 32'h1);
    end
    io_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL midframe_rx_status: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_rx;
    logic [31:0] d;
    send_frame(8'hA5, 1'b1);
    io_read(8'h04, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("[TB] FAIL rx_valid_set: got %h expected %h", d, 32'h1);
    end
    io_read(8'h0C, d);
    total++;
    if (d !== 32'h0000_00A5) begin
      bad++; $display("[TB] FAIL rx_data: got %h expected %h", d, 32'h0000_00A5);
    end
    io_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL rx_valid_cleared: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    io_read(8'h04, d);
    total++;
    if (d !== 32'h3) begin
      bad++; $display("[TB] FAIL overrun_status: got %h expected %h", d, 32'h3);
    end
    io_read(8'h0C, d);
    total++;
    if (d !== 32'h0000_0011) begin
      bad++; $display("[TB] FAIL overrun_keeps_first: got %h expected %h", d, 32'h0000_0011);
    end
    io_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL overrun_cleared: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_framing;
    logic [31:0] d;
    send_frame(8'h77, 1'b0);
    wait_cycles(10);
    io_read(8'h04, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL framing_discard: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_pop_coincide;
    logic [31:0] d;
    send_frame(8'h33, 1'b1);
    // Stop-bit sample of a frame starting at edge E0 lands on edge E0+4126.
    fork
      send_frame(8'h44, 1'b1);
      begin
        wait_cycles(4125);
        io_read(8'h0C, d);
      end
    join
    total++;
    if (d !== 32'h0000_0033) begin
      bad++; $display("[TB] FAIL coincide_old_byte: got %h expected %h", d, 32'h0000_0033);
    end
    io_read(8'h04, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("[TB] FAIL coincide_status: got %h expected %h", d, 32'h1);
    end
    io_read(8'h0C, d);
    total++;
    if (d !== 32'h0000_0044) begin
      bad++; $display("[TB] FAIL coincide_new_byte: got %h expected %h", d, 32'h0000_0044);
    end
  endtask

  task automatic test_counter;
    logic [31:0] a;
    logic [31:0] b;
    io_read(8'h10, a);
    wait_cycles(9);
    io_read(8'h10, b);
    total++;
    if (b - a !== 32'd10) begin
      bad++; $display("[TB] FAIL counter_delta: got %0d expected 10", b - a);
    end
    io_write(8'h10, 32'h0);
    wait_cycles(1);
    io_read(8'h10, a);
    total++;
    if (a !== 32'd1) begin
      bad++; $display("[TB] FAIL counter_clear: got %h expected %h", a, 32'd1);
    end
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt_q;
    io_read(8'h10, a);
    total++;
    if (a !== 32'hFFFF_FFFE) begin
      bad++; $display("[TB] FAIL counter_preload: got %h expected %h", a, 32'hFFFF_FFFE);
    end
    io_read(8'h10, a);
    total++;
    if (a !== 32'hFFFF_FFFF) begin
      bad++; $display("[TB] FAIL counter_max: got %h expected %h", a, 32'hFFFF_FFFF);
    end
    io_read(8'h10, a);
    total++;
    if (a !== 32'h0) begin
      bad++; $display("[TB] FAIL counter_wrap: got %h expected %h", a, 32'h0);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    io_read(8'h01, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("[TB] FAIL addr_low_bits_ignored: got %h expected %h", d, 32'h1);
    end
    io_read(8'h20, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL unmapped_read: got %h expected %h", d, 32'h0);
    end
    io_read(8'h00, d);
    io_read(8'h08, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("[TB] FAIL write_only_read: got %h expected %h", d, 32'h0);
    end
  endtask

  initial begin
    test_reset;
    test_tx;
    test_reset_mid_frame;
    test_rx;
    test_overrun;
    test_framing;
    test_pop_coincide;
    test_counter;
    test_unmapped;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
